datapath_sequencer: RTL

- Hardwired control unit that sequences the single-bus CPU datapath (R0-R15, HI/LO, Z, PC, IR, RY, MAR, MDR, ALU) through fetch, decode and execute.
- Each cycle it drives one bus source, the register write enables, the ALU op and the memory handshake.
- Sits beside the CPU datapath and replaces the testbench-driven select/in strobes.
- Waits on memory via a ready handshake. Supports reg-reg ALU, immediate ALU, ld, ldi, st, mfhi, mflo, nop and halt.

---
 rtl/cpu_ctrl_pkg.sv | 78 +++++++
 rtl/seq_opcode_decode.sv | 43 ++++
 rtl/datapath_sequencer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the datapath sequencer: opcodes, ALU ops, states,
// instruction classes and bus/write-enable bit positions.
package cpu_ctrl_pkg;

   // Opcodes, ir[31:27]
   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_SHR  = 5'b00111;
   localparam logic [4:0] OP_SHL  = 5'b01000;
   localparam logic [4:0] OP_ROR  = 5'b01001;
   localparam logic [4:0] OP_ROL  = 5'b01010;
   localparam logic [4:0] OP_ADDI = 5'b01011;
   localparam logic [4:0] OP_ANDI = 5'b01100;
   localparam logic [4:0] OP_ORI  = 5'b01101;
   localparam logic [4:0] OP_MUL  = 5'b01110;
   localparam logic [4:0] OP_DIV  = 5'b01111;
   localparam logic [4:0] OP_NEG  = 5'b10000;
   localparam logic [4:0] OP_NOT  = 5'b10001;
   localparam logic [4:0] OP_MFHI = 5'b11000;
   localparam logic [4:0] OP_MFLO = 5'b11001;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   // ALU operations
   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_SHR = 4'd4;
   localparam logic [3:0] ALU_SHL = 4'd5;
   localparam logic [3:0] ALU_ROR = 4'd6;
   localparam logic [3:0] ALU_ROL = 4'd7;
   localparam logic [3:0] ALU_MUL = 4'd8;
   localparam logic [3:0] ALU_DIV = 4'd9;
   localparam logic [3:0] ALU_NEG = 4'd10;
   localparam logic [3:0] ALU_NOT = 4'd11;
   localparam logic [3:0] ALU_INC = 4'd12;

   typedef enum logic [3:0] {
      S_IDLE, S_F0, S_F1, S_FW, S_F2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
   } state_t;

   typedef enum logic [3:0] {
      CL_ALU, CL_IMM, CL_LD, CL_LDI, CL_ST, CL_MULDIV, CL_UNARY,
      CL_MFHI, CL_MFLO, CL_NOP, CL_HALT, CL_BAD
   } op_class_t;

   // Bus source bits (0-15 are R0-R15)
   localparam logic [4:0] BS_HI  = 5'd16;
   localparam logic [4:0] BS_LO  = 5'd17;
   localparam logic [4:0] BS_ZHI = 5'd18;
   localparam logic [4:0] BS_ZLO = 5'd19;
   localparam logic [4:0] BS_PC  = 5'd20;
   localparam logic [4:0] BS_MDR = 5'd21;
   localparam logic [4:0] BS_INP = 5'd22;
   localparam logic [4:0] BS_C   = 5'd23;

   // Write-enable bits (0-15 are R0-R15)
   localparam logic [4:0] DE_HI  = 5'd16;
   localparam logic [4:0] DE_LO  = 5'd17;
   localparam logic [4:0] DE_Z   = 5'd18;
   localparam logic [4:0] DE_PC  = 5'd19;
   localparam logic [4:0] DE_MDR = 5'd20;
   localparam logic [4:0] DE_IR  = 5'd21;
   localparam logic [4:0] DE_RY  = 5'd22;
   localparam logic [4:0] DE_MAR = 5'd23;

   // One-hot vector with a single bit at position idx
   function automatic logic [23:0] onehot24(input logic [4:0] idx);
      onehot24 = 24'd1 << idx;
   endfunction

endpackage

// File: rtl/seq_opcode_decode.sv
// Combinational opcode decoder: instruction class, ALU op and legality.
module seq_opcode_decode
   import cpu_ctrl_pkg::*;
(
   input  logic [4:0] i_opcode,
   output op_class_t  o_class,
   output logic [3:0] o_alu_op,
   output logic       o_legal
);

   // Map each opcode to its class and ALU operation; unknown opcodes stay illegal
   always_comb begin
      o_class  = CL_BAD;
      o_alu_op = ALU_ADD;
      o_legal  = 1'b0;
      case (i_opcode)
         OP_LD:   begin o_class = CL_LD;     o_legal = 1'b1; end
         OP_LDI:  begin o_class = CL_LDI;    o_legal = 1'b1; end
         OP_ST:   begin o_class = CL_ST;     o_legal = 1'b1; end
         OP_ADD:  begin o_class = CL_ALU;    o_alu_op = ALU_ADD; o_legal = 1'b1; end
         OP_SUB:  begin o_class = CL_ALU;    o_alu_op = ALU_SUB; o_legal = 1'b1; end
         OP_AND:  begin o_class = CL_ALU;    o_alu_op = ALU_AND; o_legal = 1'b1; end
         OP_OR:   begin o_class = CL_ALU;    o_alu_op = ALU_OR;  o_legal = 1'b1; end
         OP_SHR:  begin o_class = CL_ALU;    o_alu_op = ALU_SHR; o_legal = 1'b1; end
         OP_SHL:  begin o_class = CL_ALU;    o_alu_op = ALU_SHL; o_legal = 1'b1; end
         OP_ROR:  begin o_class = CL_ALU;    o_alu_op = ALU_ROR; o_legal = 1'b1; end
         OP_ROL:  begin o_class = CL_ALU;    o_alu_op = ALU_ROL; o_legal = 1'b1; end
         OP_ADDI: begin o_class = CL_IMM;    o_alu_op = ALU_ADD; o_legal = 1'b1; end
         OP_ANDI: begin o_class = CL_IMM;    o_alu_op = ALU_AND; o_legal = 1'b1; end
         OP_ORI:  begin o_class = CL_IMM;    o_alu_op = ALU_OR;  o_legal = 1'b1; end
         OP_MUL:  begin o_class = CL_MULDIV; o_alu_op = ALU_MUL; o_legal = 1'b1; end
         OP_DIV:  begin o_class = CL_MULDIV; o_alu_op = ALU_DIV; o_legal = 1'b1; end
         OP_NEG:  begin o_class = CL_UNARY;  o_alu_op = ALU_NEG; o_legal = 1'b1; end
         OP_NOT:  begin o_class = CL_UNARY;  o_alu_op = ALU_NOT; o_legal = 1'b1; end
         OP_MFHI: begin o_class = CL_MFHI;   o_legal = 1'b1; end
         OP_MFLO: begin o_class = CL_MFLO;   o_legal = 1'b1; end
         OP_NOP:  begin o_class = CL_NOP;    o_legal = 1'b1; end
         OP_HALT: begin o_class = CL_HALT;   o_legal = 1'b1; end
         default: begin o_class = CL_BAD;    o_alu_op = ALU_ADD; o_legal = 1'b0; end
      endcase
   end

endmodule

// File: rtl/datapath_sequencer.sv
// Hardwired control unit stepping the single-bus datapath through
// fetch, decode and execute, one bus source per cycle.
module datapath_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int BUS_SRC_W = 24,
   parameter int DST_W     = 24
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 run,
   input  logic [31:0]          ir,
   input  logic                 mem_ready,
   output logic [BUS_SRC_W-1:0] bus_src,
   output logic [DST_W-1:0]     dst_en,
   output logic [3:0]           alu_op,
   output logic                 md_read,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic                 busy,
   output logic                 halted,
   output logic                 illegal
);

   state_t     r_state;
   state_t     w_next;
   state_t     w_boundary;
   op_class_t  w_class;
   logic [3:0] w_alu;
   logic       w_legal;
   logic [4:0] w_ra;
   logic [4:0] w_rb;
   logic [4:0] w_rc;
   logic [23:0] w_bus;
   logic [23:0] w_dst;
   logic       w_set_halt;
   logic       w_set_illegal;
   logic       r_halted;
   logic       r_illegal;
   logic       w_unused;

   seq_opcode_decode u_decode (
      .i_opcode (ir[31:27]),
      .o_class  (w_class),
      .o_alu_op (w_alu),
      .o_legal  (w_legal)
   );

   assign w_ra       = {1'b0, ir[26:23]};
   assign w_rb       = {1'b0, ir[22:19]};
   assign w_rc       = {1'b0, ir[18:15]};
   assign w_boundary = run ? S_F0 : S_IDLE;
   // Immediate bits go to the datapath C path, not to the controller
   assign w_unused   = ^{ir[14:0], w_legal};

   // Next-state and strobe decode from the current state and IR
   always_comb begin
      w_next        = r_state;
      w_bus         = 24'd0;
      w_dst         = 24'd0;
      alu_op        = ALU_ADD;
      md_read       = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      busy          = 1'b1;
      w_set_halt    = 1'b0;
      w_set_illegal = 1'b0;
      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (run) w_next = S_F0;
            else     w_next = S_IDLE;
         end
         S_F0: begin
            w_bus  = onehot24(BS_PC);
            w_dst  = onehot24(DE_MAR) | onehot24(DE_Z);
            alu_op = ALU_INC;
            w_next = S_F1;
         end
         S_F1: begin
            w_bus    = onehot24(BS_ZLO);
            w_dst    = onehot24(DE_PC);
            mem_read = 1'b1;
            w_next   = S_FW;
         end
         S_FW: begin
            mem_read = 1'b1;
            md_read  = 1'b1;
            if (mem_ready) begin
               w_dst  = onehot24(DE_MDR);
               w_next = S_F2;
            end else begin
               w_next = S_FW;
            end
         end
         S_F2: begin
            w_bus  = onehot24(BS_MDR);
            w_dst  = onehot24(DE_IR);
            w_next = S_T3;
         end
         S_T3: begin
            case (w_class)
               CL_MFHI: begin
                  w_bus  = onehot24(BS_HI);
                  w_dst  = onehot24(w_ra);
                  w_next = w_boundary;
               end
               CL_MFLO: begin
                  w_bus  = onehot24(BS_LO);
                  w_dst  = onehot24(w_ra);
                  w_next = w_boundary;
               end
               CL_NOP:  w_next = w_boundary;
               CL_HALT: begin
                  w_set_halt = 1'b1;
                  w_next     = S_HALT;
               end
               CL_BAD: begin
                  w_set_halt    = 1'b1;
                  w_set_illegal = 1'b1;
                  w_next        = S_HALT;
               end
               default: begin
                  w_bus  = onehot24(w_rb);
                  w_dst  = onehot24(DE_RY);
                  w_next = S_T4;
               end
            endcase
         end
         S_T4: begin
            w_dst  = onehot24(DE_Z);
            alu_op = w_alu;
            w_next = S_T5;
            case (w_class)
               CL_ALU, CL_MULDIV: w_bus = onehot24(w_rc);
               CL_UNARY:          w_bus = onehot24(w_rb);
               default:           w_bus = onehot24(BS_C);
            endcase
         end
         S_T5: begin
            w_bus = onehot24(BS_ZLO);
            case (w_class)
               CL_MULDIV: begin
                  w_dst  = onehot24(DE_LO);
                  w_next = S_T6;
               end
               CL_LD, CL_ST: begin
                  w_dst  = onehot24(DE_MAR);
                  w_next = S_T6;
               end
               default: begin
                  w_dst  = onehot24(w_ra);
                  w_next = w_boundary;
               end
            endcase
         end
         S_T6: begin
            case (w_class)
               CL_MULDIV: begin
                  w_bus  = onehot24(BS_ZHI);
                  w_dst  = onehot24(DE_HI);
                  w_next = w_boundary;
               end
               CL_LD: begin
                  mem_read = 1'b1;
                  md_read  = 1'b1;
                  if (mem_ready) begin
                     w_dst  = onehot24(DE_MDR);
                     w_next = S_T7;
                  end else begin
                     w_next = S_T6;
                  end
               end
               CL_ST: begin
                  w_bus  = onehot24(w_ra);
                  w_dst  = onehot24(DE_MDR);
                  w_next = S_T7;
               end
               default: w_next = w_boundary;
            endcase
         end
         S_T7: begin
            case (w_class)
               CL_LD: begin
                  w_bus  = onehot24(BS_MDR);
                  w_dst  = onehot24(w_ra);
                  w_next = w_boundary;
               end
               CL_ST: begin
                  mem_write = 1'b1;
                  if (mem_ready) w_next = w_boundary;
                  else           w_next = S_T7;
               end
               default: w_next = w_boundary;
            endcase
         end
         S_HALT: begin
            busy   = 1'b0;
            w_next = S_HALT;
         end
         default: begin
            busy   = 1'b0;
            w_next = S_IDLE;
         end
      endcase
   end

   assign bus_src = BUS_SRC_W'(w_bus);
   assign dst_en  = DST_W'(w_dst);
   assign halted  = r_halted;
   assign illegal = r_illegal;

   // State register and sticky halt/illegal flags
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_halted  <= 1'b0;
         r_illegal <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_halted  <= r_halted | w_set_halt;
         r_illegal <= r_illegal | w_set_illegal;
      end
   end

endmodule
